// File: rtl/mem_arbiter_if.sv
// Request/response and byte-RAM bundle shared by the IF and MEM paths of mem_arbiter.
// slave: the arbiter; master: the pipeline/RAM side that drives requests and RAM read data.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_abort_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;

  logic [7:0]        ram_din_i;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;

  modport slave (
    input  if_req_i, if_addr_i, if_abort_i,
    output if_done_o, if_data_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_done_o, mem_rdata_o,
    input  ram_din_i,
    output ram_addr_o, ram_dout_o, ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i, if_abort_i,
    input  if_done_o, if_data_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_done_o, mem_rdata_o,
    output ram_din_i,
    input  ram_addr_o, ram_dout_o, ram_wr_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the byte-wide RAM port: one IF or MEM request at a time,
// split into 1/2/4 little-endian byte accesses, one done pulse per completed request.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     data_q, data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DW-1:0]     if_data_q, if_data_d;
  logic [DW-1:0]     mem_rdata_q, mem_rdata_d;

  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        cap_idx;
  logic              if_killed;
  logic              unused_addr_bits;

  assign cnt_nxt   = cnt_q + CNT_W'(1);
  // RAM data lags its address by one cycle, so the byte arriving now belongs to cnt-1.
  assign cap_idx   = 2'(cnt_q - CNT_W'(1));
  assign if_killed = bus.if_abort_i & ~owner_mem_q;
  assign unused_addr_bits = ^{bus.if_addr_i[DW-1:ADDR_W], bus.mem_addr_i[DW-1:ADDR_W]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      base_q      <= base_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    base_d      = base_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        // MEM wins ties: it carries the older instruction.
        if (bus.mem_req_i) begin
          owner_mem_d = 1'b1;
          base_d      = bus.mem_addr_i[ADDR_W-1:0];
          ram_addr_d  = bus.mem_addr_i[ADDR_W-1:0];
          n_d         = (bus.mem_len_i == 2'b00) ? CNT_W'(1) :
                        (bus.mem_len_i == 2'b01) ? CNT_W'(2) : CNT_W'(4);
          wdata_d     = bus.mem_wdata_i;
          cnt_d       = '0;
          data_d      = '0;
          if (bus.mem_we_i) begin
            state_d    = WRITE;
            wr_d       = 1'b1;
            ram_dout_d = bus.mem_wdata_i[7:0];
          end else begin
            state_d    = READ;
          end
        end else if (bus.if_req_i && !bus.if_abort_i) begin
          owner_mem_d = 1'b0;
          base_d      = bus.if_addr_i[ADDR_W-1:0];
          ram_addr_d  = bus.if_addr_i[ADDR_W-1:0];
          n_d         = CNT_W'(4);
          cnt_d       = '0;
          data_d      = '0;
          state_d     = READ;
        end
      end

      READ: begin
        if (if_killed) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != '0) begin
            data_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
          end
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (owner_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = data_d;
            end else begin
              if_done_d   = 1'b1;
              if_data_d   = data_d;
            end
          end else begin
            cnt_d      = cnt_nxt;
            ram_addr_d = base_q + ADDR_W'(cnt_nxt);
          end
        end
      end

      WRITE: begin
        if (cnt_q == CNT_W'(n_q - CNT_W'(1))) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_nxt;
          wr_d       = 1'b1;
          ram_addr_d = base_q + ADDR_W'(cnt_nxt);
          ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // An abort during the IF done cycle suppresses the pulse; reset suppresses the in-flight write.
  assign bus.if_done_o   = if_done_q & ~bus.if_abort_i;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.ram_wr_o    = wr_q & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-indexed transaction schedule is checked every cycle,
// plus literal expectations for the reference scenarios.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 17;
  localparam int NCYC   = 256;
  localparam int NOKILL = NCYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency; pre_* loads contents while in reset.
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pre_we   = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_val  = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_val;
    else if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_addr_o];
  end

  // Expected per-cycle behaviour built from transaction rules.
  bit                e_wr   [NCYC];
  bit                e_av   [NCYC];
  logic [ADDR_W-1:0] e_addr [NCYC];
  logic [7:0]        e_dout [NCYC];
  bit                e_ifd  [NCYC];
  bit                e_memd [NCYC];
  bit                e_memv [NCYC];
  logic [31:0]       e_ifdata  [NCYC];
  logic [31:0]       e_memdata [NCYC];
  logic [7:0]        ref_mem [int];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic poke4(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      pre_we   = 1'b1;
      pre_addr = a + ADDR_W'(k);
      pre_val  = w[8*k +: 8];
      ref_mem[int'(pre_addr)] = pre_val;
      tick();
    end
    pre_we = 1'b0;
  endtask

  // Read granted at end of cycle g: addresses in g+1..g+n, done in g+n+2; nothing after 'last'.
  task automatic sched_read(input int g, input bit is_mem, input logic [ADDR_W-1:0] base,
                            input int n, input int last);
    logic [31:0]       d;
    logic [ADDR_W-1:0] a;
    int                dc;
    d  = '0;
    dc = g + n + 2;
    for (int k = 0; k < n; k++) begin
      a = base + ADDR_W'(k);
      d[8*k +: 8] = ref_mem[int'(a)];
      if (g + 1 + k <= last) begin
        e_av[g+1+k]   = 1'b1;
        e_addr[g+1+k] = a;
      end
    end
    if (dc <= last) begin
      if (is_mem) begin
        e_memd[dc] = 1'b1; e_memv[dc] = 1'b1; e_memdata[dc] = d;
      end else begin
        e_ifd[dc] = 1'b1; e_ifdata[dc] = d;
      end
    end
  endtask

  // Write granted at end of cycle g: bytes written in g+1..g+n, done in g+n+1.
  task automatic sched_write(input int g, input logic [ADDR_W-1:0] base, input int n,
                             input logic [31:0] wd, input int last);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + ADDR_W'(k);
      if (g + 1 + k <= last) begin
        e_wr[g+1+k]   = 1'b1;
        e_av[g+1+k]   = 1'b1;
        e_addr[g+1+k] = a;
        e_dout[g+1+k] = wd[8*k +: 8];
        ref_mem[int'(a)] = wd[8*k +: 8];
      end
    end
    if (g + n + 1 <= last) e_memd[g+n+1] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      chk("ram_wr",   32'(bus.ram_wr_o),   32'(e_wr[cyc]));
      chk("if_done",  32'(bus.if_done_o),  32'(e_ifd[cyc]));
      chk("mem_done", 32'(bus.mem_done_o), 32'(e_memd[cyc]));
      if (e_av[cyc])   chk("ram_addr",  32'(bus.ram_addr_o), 32'(e_addr[cyc]));
      if (e_wr[cyc])   chk("ram_dout",  32'(bus.ram_dout_o), 32'(e_dout[cyc]));
      if (e_ifd[cyc])  chk("if_data",   bus.if_data_o,   e_ifdata[cyc]);
      if (e_memv[cyc]) chk("mem_rdata", bus.mem_rdata_o, e_memdata[cyc]);
    end
  end

  initial begin
    int g;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_abort_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    tick();
    poke4(17'h00100, 32'h00000513);
    poke4(17'h00104, 32'h00100093);
    poke4(17'h00200, 32'h000000F0);
    poke4(17'h00010, 32'h005A0000);
    poke4(17'h1FFFF, 32'h44332211);
    poke4(17'h00040, 32'hE3E2E1E0);

    chk("rst ram_wr",    32'(bus.ram_wr_o),   32'h0);
    chk("rst ram_addr",  32'(bus.ram_addr_o), 32'h0);
    chk("rst ram_dout",  32'(bus.ram_dout_o), 32'h0);
    chk("rst if_done",   32'(bus.if_done_o),  32'h0);
    chk("rst mem_done",  32'(bus.mem_done_o), 32'h0);
    chk("rst if_data",   bus.if_data_o,       32'h0);
    chk("rst mem_rdata", bus.mem_rdata_o,     32'h0);
    rst = 1'b0;
    tick();

    // Word fetch at 0x100.
    g = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    sched_read(g, 1'b0, 17'h100, 4, NOKILL);
    run_to(g + 6);
    chk("A if_done lit", 32'(bus.if_done_o), 32'h1);
    chk("A if_data lit", bus.if_data_o, 32'h00000513);
    run_to(g + 7);
    bus.if_req_i = 1'b0;
    tick();

    // Simultaneous requests: MEM byte load first, then IF.
    g = cyc;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b00; bus.mem_addr_i = 32'h200;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    sched_read(g, 1'b1, 17'h200, 1, NOKILL);
    sched_read(g + 4, 1'b0, 17'h104, 4, NOKILL);
    run_to(g + 3);
    chk("B mem_done lit",  32'(bus.mem_done_o), 32'h1);
    chk("B mem_rdata lit", bus.mem_rdata_o, 32'h000000F0);
    run_to(g + 4);
    bus.mem_req_i = 1'b0;
    run_to(g + 10);
    chk("B if_data lit", bus.if_data_o, 32'h00100093);
    run_to(g + 11);
    bus.if_req_i = 1'b0;
    tick();

    // Half store at 0x10.
    g = cyc;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b01;
    bus.mem_addr_i = 32'h10; bus.mem_wdata_i = 32'hAABBCCDD;
    sched_write(g, 17'h10, 2, 32'hAABBCCDD, NOKILL);
    run_to(g + 3);
    chk("C mem_done lit", 32'(bus.mem_done_o), 32'h1);
    run_to(g + 4);
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    chk("C ram10", 32'(ram[17'h10]), 32'hDD);
    chk("C ram11", 32'(ram[17'h11]), 32'hCC);
    chk("C ram12", 32'(ram[17'h12]), 32'h5A);
    tick();

    // Fetch aborted in its cycle 3, redirected to 0x100.
    g = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    sched_read(g, 1'b0, 17'h104, 4, g + 3);
    sched_read(g + 4, 1'b0, 17'h100, 4, NOKILL);
    run_to(g + 3);
    bus.if_abort_i = 1'b1;
    run_to(g + 4);
    bus.if_abort_i = 1'b0; bus.if_addr_i = 32'h100;
    run_to(g + 6);
    chk("D no if_done lit", 32'(bus.if_done_o), 32'h0);
    run_to(g + 10);
    chk("D if_done lit", 32'(bus.if_done_o), 32'h1);
    chk("D if_data lit", bus.if_data_o, 32'h00000513);
    run_to(g + 11);
    bus.if_req_i = 1'b0;
    tick();

    // Word load wrapping past the top of the address space.
    g = cyc;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b10; bus.mem_addr_i = 32'h0001FFFF;
    sched_read(g, 1'b1, 17'h1FFFF, 4, NOKILL);
    run_to(g + 2);
    chk("E wrap addr lit", 32'(bus.ram_addr_o), 32'h0);
    run_to(g + 6);
    chk("E mem_rdata lit", bus.mem_rdata_o, 32'h44332211);
    run_to(g + 7);
    bus.mem_req_i = 1'b0;
    tick();

    // Reset during cycle 2 of a word store.
    g = cyc;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b11;
    bus.mem_addr_i = 32'h40; bus.mem_wdata_i = 32'h11223344;
    sched_write(g, 17'h40, 4, 32'h11223344, g + 1);
    run_to(g + 2);
    rst = 1'b1;
    run_to(g + 3);
    chk("F ram_addr lit",  32'(bus.ram_addr_o), 32'h0);
    chk("F ram_dout lit",  32'(bus.ram_dout_o), 32'h0);
    chk("F mem_rdata lit", bus.mem_rdata_o, 32'h0);
    chk("F if_data lit",   bus.if_data_o, 32'h0);
    chk("F ram40", 32'(ram[17'h40]), 32'h44);
    chk("F ram41", 32'(ram[17'h41]), 32'hE1);
    rst = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    tick();

    // Abort in IDLE blocks the fetch grant for one cycle only.
    g = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104; bus.if_abort_i = 1'b1;
    sched_read(g + 1, 1'b0, 17'h104, 4, NOKILL);
    run_to(g + 1);
    bus.if_abort_i = 1'b0;
    run_to(g + 7);
    chk("G if_data lit", bus.if_data_o, 32'h00100093);
    run_to(g + 8);
    bus.if_req_i = 1'b0;
    run_to(g + 11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
